// File: rtl/song_recorder.sv
// rtl/song_recorder.sv - live tone recorder that packs notes into {dur, tone} song-memory entries
//
// Purpose: while recording, watches the live tone code and counts duration ticks.
//          Each time the tone changes, a tick brings a long note to 15 units, or a
//          stop is requested, one 8-bit entry {dur[3:0], tone[3:0]} is written to
//          song memory. Entries with zero duration are dropped.
//
// Parameters:
//   MAX_ADDR - last writable song-memory address (song occupies 0..MAX_ADDR)
//   ADDR_W   - song-memory address width
//
// Ports:
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   tone_in   in   [3:0] live tone code, 0 = rest
//   tick      in   one-cycle duration-unit strobe
//   rec_start in   one-cycle request to begin a take
//   rec_stop  in   one-cycle request to end a take
//   wr_en     out  song-memory write strobe, one cycle per entry
//   wr_addr   out  [ADDR_W-1:0] song-memory write address
//   wr_data   out  [7:0] entry {dur, tone}
//   busy      out  high while recording
//   done      out  high once a take has ended
//   song_len  out  [ADDR_W-1:0] note entries written in the last or current take
//
// Configuration macro: SONG_RECORDER_TERMINATOR_EN
//   defined   - last note slot is MAX_ADDR-1; entering DONE writes a 8'h00
//               terminator the cycle after the final note write
//   undefined - last note slot is MAX_ADDR; no terminator
module song_recorder #(
    parameter int MAX_ADDR = 20,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        tone_in,
    input  logic              tick,
    input  logic              rec_start,
    input  logic              rec_stop,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] song_len
);

`ifdef SONG_RECORDER_TERMINATOR_EN
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(MAX_ADDR - 1);
    localparam logic              TERM_EN   = 1'b1;
`else
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(MAX_ADDR);
    localparam logic              TERM_EN   = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_wr_en;
    logic              r_wr_is_note;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_song_len;
    logic [3:0]        r_dur_cnt;
    logic [3:0]        r_cur_tone;
    logic              r_term_pend;

    logic [ADDR_W-1:0] w_addr_eff;
    logic [3:0]        w_dur_inc;
    logic              w_emit;
    logic [7:0]        w_emit_data;
    logic              w_load_tone;
    logic              w_clr_dur;
    logic              w_start;
    logic              w_enter_done;

    // The address advances the cycle after a write; a write landing in that
    // same cycle must already target the advanced address.
    assign w_addr_eff  = r_wr_en ? (r_wr_addr + ADDR_W'(1)) : r_wr_addr;
    // A tick coincident with a change/stop belongs to the outgoing note.
    assign w_dur_inc   = r_dur_cnt + {3'b000, tick};
    assign w_emit_data = {w_dur_inc, r_cur_tone};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_load_tone  = 1'b0;
        w_clr_dur    = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rec_start) begin
                    w_state_next = S_REC;
                    w_start      = 1'b1;
                end
            end
            S_REC: begin
                // rec_stop outranks a simultaneous tone change: one flush entry.
                if (rec_stop) begin
                    w_emit       = (w_dur_inc != 4'd0);
                    w_state_next = S_DONE;
                end else if (tone_in != r_cur_tone) begin
                    w_emit      = (w_dur_inc != 4'd0);
                    w_load_tone = 1'b1;
                    w_clr_dur   = 1'b1;
                end else if (w_dur_inc == 4'hF) begin
                    // Long note: split into a full-length entry and keep going.
                    w_emit    = 1'b1;
                    w_clr_dur = 1'b1;
                end
                if (w_emit && (w_addr_eff == LAST_SLOT)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (rec_start) begin
                    w_state_next = S_REC;
                    w_start      = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_enter_done = (r_state == S_REC) && (w_state_next == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en      <= 1'b0;
            r_wr_is_note <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 8'h00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_song_len   <= '0;
            r_dur_cnt    <= 4'd0;
            r_cur_tone   <= 4'd0;
            r_term_pend  <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_wr_is_note <= 1'b0;
            r_term_pend  <= 1'b0;
            if (w_start) begin
                r_wr_addr  <= '0;
                r_song_len <= '0;
                r_cur_tone <= tone_in;
                r_dur_cnt  <= 4'd0;
            end else begin
                r_wr_addr <= w_addr_eff;
                // The terminator is not a note and stays out of song_len.
                if (r_wr_en && r_wr_is_note) begin
                    r_song_len <= r_song_len + ADDR_W'(1);
                end
                if (r_state == S_REC) begin
                    if (w_emit) begin
                        r_wr_en      <= 1'b1;
                        r_wr_is_note <= 1'b1;
                        r_wr_data    <= w_emit_data;
                    end
                    if (w_load_tone) begin
                        r_cur_tone <= tone_in;
                    end
                    r_dur_cnt <= w_clr_dur ? 4'd0 : w_dur_inc;
                end
                if (TERM_EN && w_enter_done) begin
                    r_term_pend <= 1'b1;
                end
                if (r_term_pend) begin
                    r_wr_en   <= 1'b1;
                    r_wr_data <= 8'h00;
                end
            end
            r_busy <= (w_state_next == S_REC);
            r_done <= (w_state_next == S_DONE);
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign song_len = r_song_len;

endmodule

// File: tb/tb_song_recorder.sv
// tb/tb_song_recorder.sv - scoreboard bench for song_recorder
module tb_song_recorder;

    logic       clk;
    logic       rst;
    logic [3:0] tone_in;
    logic       tick;
    logic       rec_start;
    logic       rec_stop;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic [7:0] song_len;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];

    song_recorder #(.MAX_ADDR(20), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .tone_in   (tone_in),
        .tick      (tick),
        .rec_start (rec_start),
        .rec_stop  (rec_stop),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .song_len  (song_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every presented write must match the head of the expected queue.
    always @(negedge clk) begin
        if (wr_en) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_write addr=%0d data=%h (none expected)", wr_addr, wr_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    bad = bad + 1;
                    $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                             wr_addr, wr_data, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total = total + 1;
        if (got != want) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic drive(input logic [3:0] t, input logic tk, input logic s, input logic p);
        tone_in   = t;
        tick      = tk;
        rec_start = s;
        rec_stop  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input int a, input logic [7:0] d);
        exp_q.push_back({8'(a), d});
    endtask

    task automatic expect_term(input int a);
`ifdef SONG_RECORDER_TERMINATOR_EN
        exp_q.push_back({8'(a), 8'h00});
`else
        if (a < 0) $display("unreachable %0d", a);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_notes;
`ifdef SONG_RECORDER_TERMINATOR_EN
        n_notes = 20;
`else
        n_notes = 21;
`endif
        rst = 1'b1;
        tone_in = 4'd0; tick = 1'b0; rec_start = 1'b0; rec_stop = 1'b0;
        repeat (3) drive(4'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_song_len", song_len, 0);
        rst = 1'b0;
        drive(4'd4, 1'b1, 1'b0, 1'b1);   // ticks/stop in IDLE: ignored
        drive(4'd5, 1'b1, 1'b0, 1'b0);

        // Tone 3 for 4 ticks, then change to 5.
        drive(4'd3, 1'b0, 1'b1, 1'b0);
        chk("t1_busy", busy, 1);
        repeat (4) drive(4'd3, 1'b1, 1'b0, 1'b0);
        expect_wr(0, 8'h43);
        expect_term(1);
        drive(4'd5, 1'b0, 1'b0, 1'b0);
        chk("t1_wr_en_next_cycle", wr_en, 1);
        drive(4'd5, 1'b0, 1'b0, 1'b1);
        chk("t1_done", done, 1);
        chk("t1_busy_off", busy, 0);
        chk("t1_song_len", song_len, 1);
        repeat (2) drive(4'd0, 1'b1, 1'b0, 1'b0);

        // Tone 7 held 20 ticks, then stop: long note split.
        expect_wr(0, 8'hF7);
        expect_wr(1, 8'h57);
        expect_term(2);
        drive(4'd7, 1'b0, 1'b1, 1'b0);
        repeat (20) drive(4'd7, 1'b1, 1'b0, 1'b0);
        drive(4'd7, 1'b0, 1'b0, 1'b1);
        repeat (2) drive(4'd7, 1'b0, 1'b0, 1'b0);
        chk("t2_done", done, 1);
        chk("t2_song_len", song_len, 2);

        // Change with coincident tick after 2 ticks -> dur 3; change with 0 ticks -> no write;
        // stop with coincident tick flushes dur 1.
        expect_wr(0, 8'h32);
        expect_wr(1, 8'h16);
        expect_term(2);
        drive(4'd2, 1'b0, 1'b1, 1'b0);
        repeat (2) drive(4'd2, 1'b1, 1'b0, 1'b0);
        drive(4'd4, 1'b1, 1'b0, 1'b0);
        drive(4'd6, 1'b0, 1'b0, 1'b0);
        drive(4'd6, 1'b1, 1'b0, 1'b1);
        repeat (2) drive(4'd6, 1'b0, 1'b0, 1'b0);
        chk("t3_song_len", song_len, 2);
        chk("t3_done", done, 1);

        // Stop outranks a simultaneous tone change.
        expect_wr(0, 8'h21);
        expect_term(1);
        drive(4'd1, 1'b0, 1'b1, 1'b0);
        repeat (2) drive(4'd1, 1'b1, 1'b0, 1'b0);
        drive(4'd9, 1'b0, 1'b0, 1'b1);
        repeat (2) drive(4'd9, 1'b0, 1'b0, 1'b0);
        chk("t4_song_len", song_len, 1);

        // Reset mid-take with dur_cnt=6: outputs cleared, no flush.
        drive(4'd8, 1'b0, 1'b1, 1'b0);
        repeat (6) drive(4'd8, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        drive(4'd9, 1'b1, 1'b0, 1'b1);
        chk("t5_wr_en", wr_en, 0);
        chk("t5_wr_addr", wr_addr, 0);
        chk("t5_wr_data", wr_data, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_song_len", song_len, 0);
        rst = 1'b0;
        drive(4'd3, 1'b1, 1'b0, 1'b0);
        drive(4'd2, 1'b1, 1'b0, 1'b1);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_done", done, 0);

        // 25 back-to-back 1-tick notes alternating tone 1/2 until the song fills.
        for (int i = 0; i < n_notes; i++) begin
            expect_wr(i, (i % 2 == 0) ? 8'h11 : 8'h12);
        end
        expect_term(20);
        drive(4'd1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 25; i++) begin
            drive(((i + 1) % 2 == 0) ? 4'd1 : 4'd2, 1'b1, 1'b0, 1'b0);
        end
        repeat (3) drive(4'd5, 1'b1, 1'b0, 1'b0);
        chk("t6_done", done, 1);
        chk("t6_busy", busy, 0);
        chk("t6_song_len", song_len, n_notes);

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/song_recorder.md
SONG_RECORDER -- requirements
Module: song_recorder

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 20, meaning the last writable song-memory address (song occupies 0..MAX_ADDR).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the song-memory address width.
REQ-003 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tone_in  input  4  live tone code from player controls; 0 = rest.
REQ-006 SHALL have port tick  input  1  one-cycle duration-unit strobe.
REQ-007 SHALL have port rec_start  input  1  one-cycle request to begin recording.
REQ-008 SHALL have port rec_stop  input  1  one-cycle request to end recording.
REQ-009 SHALL have port wr_en  output  1  song-memory write strobe, one cycle per entry.
REQ-010 SHALL have port wr_addr  output  ADDR_W  song-memory write address.
REQ-011 SHALL have port wr_data  output  8  entry {dur[3:0], tone[3:0]}.
REQ-012 SHALL have port busy  output  1  high in REC.
REQ-013 SHALL have port done  output  1  high in DONE.
REQ-014 SHALL have port song_len  output  ADDR_W  count of note entries written in the last or current take.

Function
REQ-015 SHALL implement states IDLE, REC, DONE; IDLE->REC and DONE->REC on rec_start; REC->DONE on rec_stop or full.
REQ-016 SHALL, on entering REC, clear wr_addr and song_len to 0, load cur_tone from tone_in, clear dur_cnt to 0.
REQ-017 SHALL, in REC, increment 4-bit dur_cnt on each tick.
REQ-018 SHALL, in REC, emit entry {dur_cnt+tick, cur_tone} when tone_in != cur_tone, then load cur_tone from tone_in and clear dur_cnt; a tick coincident with the change counts toward the outgoing note.
REQ-019 SHALL discard (not write) an entry whose duration is 0.
REQ-020 SHALL, when a tick takes dur_cnt to 15 with tone unchanged, emit {4'hF, cur_tone} and clear dur_cnt (long notes split).
REQ-021 SHALL register all outputs: wr_en/wr_addr/wr_data valid the cycle after the triggering event; wr_addr increments and song_len increments the cycle after each write.
REQ-022 SHALL, on rec_stop in REC, flush a pending nonzero-duration entry (including a same-cycle tick) and enter DONE.
REQ-023 SHALL treat the write to the last note slot as full: enter DONE after that write, ignoring further tones and ticks.
REQ-024 SHALL give rec_stop priority over simultaneous tone change (single flush entry with the outgoing note) and rec_start priority over rec_stop outside REC; rec_start in REC SHALL be ignored.
REQ-025 SHALL ignore tick, tone_in and rec_stop in IDLE and DONE; wr_en SHALL never assert in IDLE.

Reset
REQ-026 SHALL, with rst high at a clk edge, enter IDLE and clear wr_en, wr_addr, wr_data, busy, done, song_len, dur_cnt, cur_tone to 0, aborting any take mid-operation without a flush write.

Configuration
REQ-027 SHALL honour macro SONG_RECORDER_TERMINATOR_EN: when defined, last note slot is MAX_ADDR-1 and entering DONE writes terminator 8'h00 at wr_addr the cycle after the final note write (not counted in song_len); when undefined, last note slot is MAX_ADDR and no terminator is written.

Verification
REQ-028 SHALL verify: rec_start, tone_in=3 for 4 ticks, then tone_in=5 -> one write wr_addr=0, wr_data=8'h43, one cycle after change.
REQ-029 SHALL verify: tone_in=7 held 20 ticks, then rec_stop -> writes 8'hF7 at 0, 8'h57 at 1, done=1, song_len=2.
REQ-030 SHALL verify: tone change with tick same cycle after 2 ticks -> entry duration 3; tone change with 0 ticks -> no write.
REQ-031 SHALL verify: 25 alternating 1-tick notes, MAX_ADDR=20, macro undefined -> 21 writes (addr 0..20), done=1, song_len=21, later ticks produce no writes.
REQ-032 SHALL verify: macro defined, same stimulus -> 20 note writes (0..19), then 8'h00 at addr 20, song_len=20.
REQ-033 SHALL verify: rst asserted mid-take with dur_cnt=6 -> next cycle all outputs 0, state IDLE, no flush write.
